csb_arbiter: RTL and testbench

Round-robin arbiter that shares one NVDLA CSB target port among `N_REQ` requesters, e.g. the HWPE register front-end, a debug bridge and a test sequencer. It accepts one request at a time and drives it onto the CSB with valid/ready. It waits for the matching read data or write completion and returns that response only to the requester that issued the transaction. A timeout counter converts a lost response into an error response, so a hung CSB target cannot deadlock the requesters.

---
 rtl/csb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/csb_arbiter.sv | 143 ++++++++++++++
 tb/tb_csb_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csb_pkg.sv
// rtl/csb_pkg.sv - shared types and constants for the CSB requester arbiter
package csb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        RESPOND  = 2'd3
    } csb_arb_state_e;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdat;
        logic        write;
        logic        nposted;
    } csb_req_t;

    localparam logic [31:0] CSB_ERR_DATA = 32'h0;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
    parameter int N = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic [IW:0] idx;
    logic        found;

    // Scan last+1, last+2, ... wrapping modulo N; first requester seen wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 1; k <= N; k++) begin
            idx = {1'b0, last} + (IW+1)'(k);
            if (idx >= (IW+1)'(N)) begin
                idx = idx - (IW+1)'(N);
            end
            if (!found && req[idx[IW-1:0]]) begin
                found              = 1'b1;
                gnt[idx[IW-1:0]]   = 1'b1;
                gnt_idx            = idx[IW-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/csb_arbiter.sv
// rtl/csb_arbiter.sv - shares one CSB target among N_REQ requesters with response timeout
module csb_arbiter
    import csb_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT     = 1024,
    parameter bit POSTED_WAIT = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic [N_REQ-1:0][15:0] req_addr_i,
    input  logic [N_REQ-1:0][31:0] req_wdat_i,
    input  logic [N_REQ-1:0]       req_write_i,
    input  logic [N_REQ-1:0]       req_nposted_i,
    output logic [N_REQ-1:0]       rsp_r_valid_o,
    output logic [N_REQ-1:0]       rsp_wr_complete_o,
    output logic [31:0]            rsp_r_data_o,
    output logic                   rsp_err_o,
    output logic                   csb_valid_o,
    input  logic                   csb_ready_i,
    output logic [15:0]            csb_addr_o,
    output logic [31:0]            csb_wdat_o,
    output logic                   csb_write_o,
    output logic                   csb_nposted_o,
    input  logic                   csb_r_valid_i,
    input  logic [31:0]            csb_r_data_i,
    input  logic                   csb_wr_complete_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    csb_arb_state_e state, state_nxt;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;
    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    cur_g;
    csb_req_t         cur_req;
    logic [CW-1:0]    tmo_cnt;
    logic [31:0]      rsp_data;
    logic             rsp_err;
    logic [N_REQ-1:0] g_onehot;
    logic             posted_done;
    logic             rsp_hit;
    logic             tmo_hit;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req_valid_i),
        .last    (last_grant),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    assign g_onehot    = N_REQ'(1) << cur_g;
    assign posted_done = cur_req.write && !cur_req.nposted && !POSTED_WAIT;
    assign rsp_hit     = cur_req.write ? csb_wr_complete_i : csb_r_valid_i;
    assign tmo_hit     = (tmo_cnt >= TMO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (gnt_any) state_nxt = ISSUE;
            ISSUE:    if (csb_ready_i) state_nxt = posted_done ? IDLE : WAIT_RSP;
            WAIT_RSP: if (rsp_hit || tmo_hit) state_nxt = RESPOND;
            RESPOND:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // The grant is gated by rst_n so no accept pulse leaks out while reset is held.
    always_comb begin
        req_ready_o       = '0;
        csb_valid_o       = 1'b0;
        rsp_r_valid_o     = '0;
        rsp_wr_complete_o = '0;
        unique case (state)
            IDLE:    if (rst_n) req_ready_o = gnt;
            ISSUE:   csb_valid_o = 1'b1;
            RESPOND: begin
                if (cur_req.write) rsp_wr_complete_o = g_onehot;
                else               rsp_r_valid_o     = g_onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= IW'(N_REQ - 1);
            cur_g      <= '0;
            cur_req    <= '0;
            tmo_cnt    <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && gnt_any) begin
                cur_g      <= gnt_idx;
                last_grant <= gnt_idx;
                cur_req    <= '{addr:    req_addr_i[gnt_idx],
                                wdat:    req_wdat_i[gnt_idx],
                                write:   req_write_i[gnt_idx],
                                nposted: req_nposted_i[gnt_idx]};
            end
            if (state == ISSUE && csb_ready_i) begin
                tmo_cnt <= '0;
            end else if (state == WAIT_RSP && tmo_cnt != {CW{1'b1}}) begin
                tmo_cnt <= tmo_cnt + CW'(1);
            end
            // A real response seen on the last counted cycle still beats the timeout.
            if (state == WAIT_RSP) begin
                if (rsp_hit) begin
                    rsp_err <= 1'b0;
                    if (!cur_req.write) rsp_data <= csb_r_data_i;
                end else if (tmo_hit) begin
                    rsp_err  <= 1'b1;
                    rsp_data <= CSB_ERR_DATA;
                end
            end
        end
    end

    assign csb_addr_o    = cur_req.addr;
    assign csb_wdat_o    = cur_req.wdat;
    assign csb_write_o   = cur_req.write;
    assign csb_nposted_o = cur_req.nposted;
    assign rsp_r_data_o  = rsp_data;
    assign rsp_err_o     = rsp_err;

endmodule

// File: tb/tb_csb_arbiter.sv
// tb/tb_csb_arbiter.sv - randomized and directed bench for csb_arbiter against a transaction model
module tb_csb_arbiter;

    localparam int N  = 3;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      rq_valid, rq_ready, rq_write, rq_np;
    logic [N-1:0][15:0] rq_addr;
    logic [N-1:0][31:0] rq_wdat;
    logic [N-1:0]      rsp_rv, rsp_wc;
    logic [31:0]       rsp_data;
    logic              rsp_err;
    logic              csb_valid, csb_ready, csb_write, csb_np;
    logic [15:0]       csb_addr;
    logic [31:0]       csb_wdat, csb_r_data;
    logic              csb_r_valid, csb_wr_complete;

    csb_arbiter #(.N_REQ(N), .TIMEOUT(TO), .POSTED_WAIT(1'b0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req_valid_i       (rq_valid),
        .req_ready_o       (rq_ready),
        .req_addr_i        (rq_addr),
        .req_wdat_i        (rq_wdat),
        .req_write_i       (rq_write),
        .req_nposted_i     (rq_np),
        .rsp_r_valid_o     (rsp_rv),
        .rsp_wr_complete_o (rsp_wc),
        .rsp_r_data_o      (rsp_data),
        .rsp_err_o         (rsp_err),
        .csb_valid_o       (csb_valid),
        .csb_ready_i       (csb_ready),
        .csb_addr_o        (csb_addr),
        .csb_wdat_o        (csb_wdat),
        .csb_write_o       (csb_write),
        .csb_nposted_o     (csb_np),
        .csb_r_valid_i     (csb_r_valid),
        .csb_r_data_i      (csb_r_data),
        .csb_wr_complete_i (csb_wr_complete)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    // Transaction-level model: one outstanding transaction, stage 0 = on the bus,
    // 1 = awaiting response, 2 = response being returned.
    bit          m_busy;
    int          m_stage, m_wait, m_g, m_last;
    logic [15:0] m_addr;
    logic [31:0] m_wdat, m_data;
    logic        m_write, m_np, m_err;
    logic [N-1:0] drop_mask;
    logic [31:0] echo_data;

    int          glog[$];
    int          hs_count, hs_cyc, vcount, rsp_count, rsp_cyc, wc_count;
    logic [N-1:0] rsp_vec;
    logic [31:0] rsp_data_l;
    logic        rsp_err_l;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic int rr_pick(int last, logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_stage = 0; m_wait = 0; m_last = N - 1; drop_mask = '0;
    endfunction

    task automatic check_cycle();
        logic [N-1:0] e_ready, e_rv, e_wc;
        int g;
        bit hit;
        cyc++;
        e_ready = '0; e_rv = '0; e_wc = '0; g = -1;
        if (!m_busy) begin
            g = rr_pick(m_last, rq_valid);
            if (g >= 0) e_ready[g] = 1'b1;
        end else if (m_stage == 2) begin
            if (m_write) e_wc[m_g] = 1'b1;
            else         e_rv[m_g] = 1'b1;
        end
        chk("req_ready", 64'(rq_ready), 64'(e_ready));
        chk("csb_valid", 64'(csb_valid), 64'(m_busy && m_stage == 0));
        if (m_busy && m_stage == 0) begin
            chk("csb_addr", 64'(csb_addr), 64'(m_addr));
            chk("csb_wdat", 64'(csb_wdat), 64'(m_wdat));
            chk("csb_write", 64'(csb_write), 64'(m_write));
            chk("csb_nposted", 64'(csb_np), 64'(m_np));
        end
        chk("rsp_r_valid", 64'(rsp_rv), 64'(e_rv));
        chk("rsp_wr_complete", 64'(rsp_wc), 64'(e_wc));
        if (|e_rv || |e_wc) chk("rsp_err", 64'(rsp_err), 64'(m_err));
        if (|e_rv) chk("rsp_r_data", 64'(rsp_data), 64'(m_data));

        for (int i = 0; i < N; i++) if (rq_ready[i]) glog.push_back(i);
        if (csb_valid) vcount++;
        if (csb_valid && csb_ready) begin hs_count++; hs_cyc = cyc; end
        if (|rsp_rv || |rsp_wc) begin
            rsp_count++; rsp_cyc = cyc; rsp_vec = rsp_rv | rsp_wc;
            rsp_data_l = rsp_data; rsp_err_l = rsp_err;
        end
        if (|rsp_wc) wc_count++;

        if (!m_busy) begin
            if (g >= 0) begin
                m_busy = 1; m_stage = 0; m_g = g; m_last = g;
                m_addr = rq_addr[g]; m_wdat = rq_wdat[g];
                m_write = rq_write[g]; m_np = rq_np[g];
                drop_mask[g] = 1'b1;
            end
        end else begin
            case (m_stage)
                0: if (csb_ready) begin
                    if (m_write && !m_np) m_busy = 0;
                    else begin m_stage = 1; m_wait = 0; end
                end
                1: begin
                    hit = m_write ? csb_wr_complete : csb_r_valid;
                    if (hit) begin
                        m_err = 1'b0; m_stage = 2;
                        if (!m_write) m_data = csb_r_data;
                    end else if (m_wait == TO - 1) begin
                        m_err = 1'b1; m_data = 32'h0; m_stage = 2;
                    end else begin
                        m_wait++;
                    end
                end
                default: m_busy = 0;
            endcase
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        rq_valid  = rq_valid & ~drop_mask;
        drop_mask = '0;
    endtask

    task automatic new_req(int i, logic wr, logic np, logic [15:0] a, logic [31:0] d);
        rq_valid[i] = 1'b1; rq_write[i] = wr; rq_np[i] = np; rq_addr[i] = a; rq_wdat[i] = d;
    endtask

    // 0 quiet, 1 ready + answer one cycle after accept, 2 random, 3 ready but never a matching read answer
    task automatic tgt(int mode);
        csb_ready = 1'b0; csb_r_valid = 1'b0; csb_wr_complete = 1'b0;
        case (mode)
            1: begin
                csb_ready = 1'b1;
                if (m_busy && m_stage == 1 && m_wait == 0) begin
                    if (m_write) csb_wr_complete = 1'b1;
                    else begin csb_r_valid = 1'b1; csb_r_data = echo_data; end
                end
            end
            2: begin
                csb_ready       = ($urandom_range(0, 99) < 65);
                csb_r_valid     = ($urandom_range(0, 99) < 25);
                csb_wr_complete = ($urandom_range(0, 99) < 25);
                csb_r_data      = $urandom();
            end
            3: begin
                csb_ready       = 1'b1;
                csb_wr_complete = ($urandom_range(0, 1) == 1);
            end
            default: ;
        endcase
    endtask

    task automatic wait_rsp(int mode, int maxc);
        int r0;
        r0 = rsp_count;
        for (int k = 0; k < maxc && rsp_count == r0; k++) begin
            step();
            tgt(mode);
        end
        chk("rsp_seen", 64'(rsp_count - r0), 64'd1);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_req_ready"}, 64'(rq_ready), 64'd0);
        chk({tag, "_csb_valid"}, 64'(csb_valid), 64'd0);
        chk({tag, "_csb_addr"}, 64'(csb_addr), 64'd0);
        chk({tag, "_csb_wdat"}, 64'(csb_wdat), 64'd0);
        chk({tag, "_csb_wr_np"}, 64'({csb_write, csb_np}), 64'd0);
        chk({tag, "_rsp_pulses"}, 64'({rsp_rv, rsp_wc}), 64'd0);
        chk({tag, "_rsp_data_err"}, 64'({rsp_data, rsp_err}), 64'd0);
    endtask

    int hs0, v0, wc0, held;
    bit strayed;
    int exp_g[6];

    initial begin
        rst_n = 1'b0;
        rq_valid = '0; rq_write = '0; rq_np = '0; rq_addr = '0; rq_wdat = '0;
        csb_ready = 1'b0; csb_r_valid = 1'b0; csb_wr_complete = 1'b0; csb_r_data = '0;
        echo_data = 32'hDEADBEEF;
        model_reset();
        rq_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("por");
        rq_valid = '0;
        rst_n = 1'b1;
        step(); step();

        // Single read from req0, response in the fourth cycle counted from req_valid.
        new_req(0, 1'b0, 1'b0, 16'h0040, 32'h0);
        v0 = cyc + 1;
        tgt(1);
        wait_rsp(1, 20);
        chk("rd_latency", 64'(rsp_cyc - v0), 64'd3);
        chk("rd_vec", 64'(rsp_vec), 64'b001);
        chk("rd_data", 64'(rsp_data_l), 64'hDEADBEEF);
        chk("rd_err", 64'(rsp_err_l), 64'd0);
        step();

        // Target stalls 5 cycles: one transaction, valid held for 6 cycles.
        hs0 = hs_count; v0 = vcount; held = 0;
        new_req(2, 1'b1, 1'b1, 16'h0200, 32'hA5A55A5A);
        for (int k = 0; k < 30; k++) begin
            step();
            tgt(1);
            if (m_busy && m_stage == 0) begin
                csb_ready = (held >= 5);
                held++;
            end
        end
        chk("stall_valid_cycles", 64'(vcount - v0), 64'd6);
        chk("stall_issues", 64'(hs_count - hs0), 64'd1);
        chk("stall_rsp_vec", 64'(rsp_vec), 64'b100);

        // Read that never gets its answer times out TO cycles after WAIT_RSP is entered.
        new_req(1, 1'b0, 1'b0, 16'h0300, 32'h0);
        wait_rsp(3, 30);
        chk("tmo_delay", 64'(rsp_cyc - hs_cyc), 64'(TO + 1));
        chk("tmo_vec", 64'(rsp_vec), 64'b010);
        chk("tmo_err", 64'(rsp_err_l), 64'd1);
        chk("tmo_data", 64'(rsp_data_l), 64'd0);
        tgt(0); step();

        // Posted write with a stray completion while idle, then a normal read.
        hs0 = hs_count; wc0 = wc_count; strayed = 0;
        new_req(0, 1'b1, 1'b0, 16'h0100, 32'h11112222);
        for (int k = 0; k < 12; k++) begin
            step();
            tgt(1);
            if (!strayed && hs_count > hs0) begin csb_wr_complete = 1'b1; strayed = 1; end
        end
        chk("posted_issues", 64'(hs_count - hs0), 64'd1);
        chk("posted_no_wc", 64'(wc_count - wc0), 64'd0);
        echo_data = 32'hCAFE0004;
        new_req(0, 1'b0, 1'b0, 16'h0104, 32'h0);
        wait_rsp(1, 20);
        chk("post_rd_vec", 64'(rsp_vec), 64'b001);
        chk("post_rd_data", 64'(rsp_data_l), 64'hCAFE0004);
        chk("post_rd_err", 64'(rsp_err_l), 64'd0);
        tgt(0); step();

        // Reset while waiting for a response aborts everything.
        new_req(0, 1'b0, 1'b0, 16'h0400, 32'h0);
        for (int k = 0; k < 10 && !(m_busy && m_stage == 1); k++) begin step(); tgt(3); end
        chk("reached_wait", 64'(m_busy && m_stage == 1), 64'd1);
        new_req(1, 1'b0, 1'b0, 16'h0500, 32'h0);
        step(); tgt(3);
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("async");
        model_reset();
        tgt(0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // After reset req0 wins first; two continuous requesters alternate.
        glog.delete();
        new_req(0, 1'b0, 1'b0, 16'h0600, 32'h0);
        for (int k = 0; k < 200 && glog.size() < 6; k++) begin
            step();
            tgt(1);
            for (int i = 0; i < 2; i++) begin
                if (!rq_valid[i] && glog.size() < 6)
                    new_req(i, 1'b0, 1'b0, 16'(16'h0700 + i), 32'h0);
            end
        end
        for (int k = 0; k < 40 && (m_busy || |rq_valid); k++) begin step(); tgt(1); end
        chk("fair_grants", 64'(glog.size() >= 6), 64'd1);
        exp_g = '{0, 1, 0, 1, 0, 1};
        for (int i = 0; i < 6 && i < glog.size(); i++) chk("fair_order", 64'(glog[i]), 64'(exp_g[i]));

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (!rq_valid[i] && $urandom_range(0, 99) < 35)
                    new_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            16'($urandom()), $urandom());
            end
            tgt(2);
        end
        for (int k = 0; k < 500 && (m_busy || |rq_valid); k++) begin step(); tgt(2); end
        chk("drained", 64'(m_busy || |rq_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
